ib_lut_page_loader: RTL
=======================

Name: ib_lut_page_loader

Overview:
- Sequences the per-iteration update of the symmetric IB-CNU LUT RAMs that feed the CNU6 f3 stage.
- Accepts a streamed sequence of LUT pages from an upstream source and drives page_addr_ram, ram_write_data and ib_ram_we into the inactive multi-frame half of the RAMs.
- Once the datapath reports idle, it swaps read_addr_offset so the readers switch to the freshly loaded half (ping-pong).
- Also counts completed iteration loads.

Parameters:
- ENTRY_ADDR, 6, page-address width including the MSB frame-offset bit; pages per half = 2^(ENTRY_ADDR-1) = 32.
- LUT_PORT_SIZE, 3, width of one bank's LUT word.
- BANK_NUM, 2, number of banks packed per write beat.
- ITER_MAX, 8, number of iterations per decode; iteration counter wraps after ITER_MAX loads.
- ITER_WIDTH, 3, width of cur_iter (clog2 of ITER_MAX).

Ports:
- write_clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse: begin loading one iteration's LUT set.
- load_abort  in  1  abandon the current load; no swap is performed.
- src_valid  in  1  upstream beat valid.
- src_data  in  LUT_PORT_SIZE*BANK_NUM  one page: bank0 in the upper LUT_PORT_SIZE bits, bank1 in the lower bits.
- src_ready  out  1  loader accepts a beat.
- pipe_idle  in  1  CNU/VNU datapath has no read in flight; a swap is permitted.
- page_addr_ram  out  ENTRY_ADDR  RAM write address; MSB = write frame offset, lower bits = page index.
- ram_write_data  out  LUT_PORT_SIZE*BANK_NUM  RAM write data.
- ib_ram_we  out  1  RAM write enable.
- read_addr_offset  out  1  active read half, forwarded to the f3 RAM read_addr_offset inputs.
- busy  out  1  state != IDLE.
- load_done  out  1  one-cycle pulse on the swap.
- cur_iter  out  ITER_WIDTH  number of completed loads mod ITER_MAX.
- decode_last  out  1  one-cycle pulse, concurrent with load_done, when cur_iter wraps from ITER_MAX-1 to 0.
- err_overrun  out  1  sticky; set when load_start arrives while busy. Cleared only by rst.

Behaviour:
- Reset: every output is 0, including read_addr_offset. page counter = 0, state = IDLE. rst overrides all other inputs in the same cycle. rst during LOAD leaves both halves' contents undefined from the datapath's view and issues no swap.
- States: IDLE, LOAD, WAIT_SWAP.
- IDLE:
  - load_start=1 -> LOAD. page_cnt is cleared and wr_off is latched as ~read_addr_offset.
  - Any other input is ignored.
- LOAD:
  - src_ready = 1.
  - Beat accepted when src_valid & src_ready.
  - Exactly 1 cycle after acceptance: ib_ram_we=1, page_addr_ram = {wr_off, page_cnt}, ram_write_data = src_data; then page_cnt increments.
  - In any cycle without an accepted beat in the prior cycle: ib_ram_we=0, and address/data hold their last values.
  - Acceptance of page 2^(ENTRY_ADDR-1)-1 -> WAIT_SWAP; src_ready drops in that same next cycle. The final write still occurs during the first WAIT_SWAP cycle.
  - Pages are written strictly in order 0..31, with no gaps or repeats.
- WAIT_SWAP:
  - src_ready = 0.
  - When pipe_idle=1 and the final write has completed: toggle read_addr_offset, pulse load_done, increment cur_iter (wrap at ITER_MAX-1 -> 0, pulsing decode_last on wrap), then go to IDLE.
  - pipe_idle already high on entry: the swap happens in the cycle after the final write, never in the same cycle.
- load_abort (LOAD or WAIT_SWAP): next state IDLE, no swap, cur_iter unchanged. A beat accepted in the abort cycle is dropped (no write). A pending registered write from the previous cycle still completes. Abort in IDLE is ignored.
- Simultaneous events:
  - load_start and load_abort together in IDLE: start wins.
  - load_start while busy: ignored for sequencing and sets err_overrun.
- read_addr_offset changes only on a swap, so the reader half is never written while active. Writes always target wr_off != read_addr_offset.

Test Plan:
- Reset, then load_start with src_valid held high and src_data = page index:
  - 32 writes on consecutive cycles, addresses 0x20..0x3F, data 0..31.
  - pipe_idle=1 -> swap 1 cycle after the last write; read_addr_offset = 1, load_done pulses once, cur_iter = 1.
- Second load after the first:
  - addresses 0x00..0x1F; after the swap, read_addr_offset = 0.
  - Toggle src_valid every other cycle: writes occur only 1 cycle after accepted beats, still 32 writes total, in order.
- Hold pipe_idle=0 for 10 cycles after the last write:
  - busy=1, no swap, ib_ram_we=0 throughout.
  - Raise pipe_idle -> swap in the next cycle.
- Pulse load_start at page 10 while busy:
  - err_overrun = 1 and stays set; the sequence is unaffected.
  - Assert load_abort at page 20: pages 0..19 written, beat 20 not written, no swap, cur_iter unchanged, state IDLE.
- Run 8 complete loads:
  - cur_iter wraps 7 -> 0 with decode_last pulsing together with the 8th load_done.
  - Assert rst mid-LOAD of a 9th load: all outputs 0 on the next cycle, including read_addr_offset and err_overrun.

Source files
------------

// File: rtl/ib_lut_page_loader.sv
// Streams one iteration's IB-CNU LUT pages into the inactive RAM half, then
// ping-pongs read_addr_offset once the datapath is idle.
module ib_lut_page_loader #(
  parameter int ENTRY_ADDR    = 6,
  parameter int LUT_PORT_SIZE = 3,
  parameter int BANK_NUM      = 2,
  parameter int ITER_MAX      = 8,
  parameter int ITER_WIDTH    = 3
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              load_abort,
  input  logic                              src_valid,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
  output logic                              src_ready,
  input  logic                              pipe_idle,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
  output logic                              ib_ram_we,
  output logic                              read_addr_offset,
  output logic                              busy,
  output logic                              load_done,
  output logic [ITER_WIDTH-1:0]             cur_iter,
  output logic                              decode_last,
  output logic                              err_overrun
);

  localparam int PAGE_W = ENTRY_ADDR - 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t            state, state_nx;
  logic [PAGE_W-1:0] page_cnt;
  logic              wr_off;
  logic              accept;
  logic              write_beat;
  logic              last_beat;
  logic              swap;
  logic              iter_wrap;

  always_ff @(posedge write_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (load_start) state_nx = LOAD;
      LOAD: begin
        if (load_abort)     state_nx = IDLE;
        else if (last_beat) state_nx = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (load_abort)     state_nx = IDLE;
        else if (pipe_idle) state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    src_ready  = (state == LOAD);
    busy       = (state != IDLE);
    accept     = src_ready & src_valid;
    write_beat = accept & ~load_abort;
    last_beat  = accept & (page_cnt == '1);
    // The final write is issued in the first WAIT_SWAP cycle, so a swap decided
    // in any WAIT_SWAP cycle is always visible strictly after that write.
    swap       = (state == WAIT_SWAP) & pipe_idle & ~load_abort;
    iter_wrap  = (cur_iter == ITER_WIDTH'(ITER_MAX - 1));
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      page_cnt         <= '0;
      wr_off           <= 1'b0;
      page_addr_ram    <= '0;
      ram_write_data   <= '0;
      ib_ram_we        <= 1'b0;
      read_addr_offset <= 1'b0;
      load_done        <= 1'b0;
      decode_last      <= 1'b0;
      cur_iter         <= '0;
      err_overrun      <= 1'b0;
    end else begin
      ib_ram_we   <= write_beat;
      load_done   <= swap;
      decode_last <= swap & iter_wrap;
      if (write_beat) begin
        page_addr_ram  <= {wr_off, page_cnt};
        ram_write_data <= src_data;
        page_cnt       <= page_cnt + PAGE_W'(1);
      end
      if (state == IDLE && load_start) begin
        page_cnt <= '0;
        wr_off   <= ~read_addr_offset;
      end
      if (swap) begin
        read_addr_offset <= ~read_addr_offset;
        cur_iter         <= iter_wrap ? '0 : cur_iter + ITER_WIDTH'(1);
      end
      if (load_start && state != IDLE) err_overrun <= 1'b1;
    end
  end

endmodule
